// File: rtl/glhf_uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a small output FIFO on a valid/ready port,
// and single-cycle framing/overrun error pulses.
module glhf_uart_rx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       rx_in,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic          rx_meta_q, rx_s_q, rx_prev_q;
  logic          fall;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          push, pop, room, empty, full, tick;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;

  // Synchroniser and edge history preset high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign fall = rx_prev_q & ~rx_s_q;
  assign tick = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d = S_START;
          cnt_d   = HALF_LOAD;
        end
      end
      S_START: begin
        if (!tick) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!rx_s_q) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
          cnt_d   = FULL_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d[idx_q] = rx_s_q;
          cnt_d          = FULL_LOAD;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rx_s_q) begin
          state_d = S_IDLE;
          if (room) push      = 1'b1;
          else      overrun_d = 1'b1;
        end else begin
          state_d     = S_BREAK;
          frame_err_d = 1'b1;
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Deselection abandons any partial frame; the FIFO side keeps running.
    if (!ena) begin
      state_d     = S_IDLE;
      push        = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);
  assign pop   = m_valid & m_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign room  = ~full | pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  assign m_valid   = ~empty;
  assign m_data    = m_valid ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_glhf_uart_rx.sv
// Bench for glhf_uart_rx: drives 8N1 frames bit by bit and checks the received byte
// stream and error pulses against a queue model of the output FIFO.
module tb_glhf_uart_rx;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       rx_in = 1'b1;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_valid, frame_err, overrun, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fe_cnt = 0, ov_cnt = 0, vld_cnt = 0;
  byte unsigned pop_q[$];
  int           pop_cyc[$];
  byte unsigned model_fifo[$];
  int           exp_ov;

  glhf_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ena(ena), .rx_in(rx_in),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the output side on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) begin
        pop_q.push_back(m_data);
        pop_cyc.push_back(cyc);
      end
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (overrun)   ov_cnt <= ov_cnt + 1;
      if (m_valid)   vld_cnt <= vld_cnt + 1;
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1 rx_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      #1 rx_in = b[i];
    end
    repeat (CPB) @(posedge clk);
    #1 rx_in = stop_bit;
    repeat (CPB) @(posedge clk);
  endtask

  // Model: a good frame lands in the FIFO if there is room, otherwise it is an overrun.
  task automatic model_rx(input byte unsigned b);
    if (model_fifo.size() < DEPTH) model_fifo.push_back(b);
    else exp_ov++;
  endtask

  task automatic drain();
    @(posedge clk); #1 m_ready = 1'b1;
    repeat (DEPTH + 4) @(posedge clk);
    #1 m_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({m_valid, frame_err, overrun, busy, m_data} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=000", {m_valid, frame_err, overrun, busy, m_data});
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_single();
    int v0, f0, o0;
    pop_q.delete();
    v0 = vld_cnt; f0 = fe_cnt; o0 = ov_cnt;
    m_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    repeat (4) @(posedge clk);
    #1 m_ready = 1'b0;
    total++;
    if (pop_q.size() !== 1) begin
      bad++; $display("FAIL single_count got=%0d exp=1", pop_q.size());
    end
    if (pop_q.size() >= 1) begin
      total++;
      if (pop_q[0] !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", pop_q[0]); end
    end
    total++;
    if (vld_cnt - v0 !== 1) begin bad++; $display("FAIL single_valid_cycles got=%0d exp=1", vld_cnt - v0); end
    total++;
    if ((fe_cnt - f0) + (ov_cnt - o0) !== 0) begin
      bad++; $display("FAIL single_errors got=%0d exp=0", (fe_cnt - f0) + (ov_cnt - o0));
    end
  endtask

  task automatic test_fifo_fill();
    byte unsigned bytes[3] = '{8'h00, 8'hFF, 8'h3C};
    model_fifo.delete(); exp_ov = 0;
    m_ready = 1'b0;
    foreach (bytes[i]) begin
      send_frame(bytes[i], 1'b1);
      model_rx(bytes[i]);
    end
    repeat (2) @(posedge clk); #1;
    total++;
    if (m_valid !== 1'b1 || m_data !== model_fifo[0]) begin
      bad++; $display("FAIL fill_head got=%b/%h exp=1/%h", m_valid, m_data, model_fifo[0]);
    end
    repeat (5) @(posedge clk); #1;
    total++;
    if (m_valid !== 1'b1 || m_data !== model_fifo[0]) begin
      bad++; $display("FAIL fill_hold got=%b/%h exp=1/%h", m_valid, m_data, model_fifo[0]);
    end
    pop_q.delete(); pop_cyc.delete();
    drain();
    total++;
    if (pop_q.size() !== model_fifo.size()) begin
      bad++; $display("FAIL fill_count got=%0d exp=%0d", pop_q.size(), model_fifo.size());
    end
    for (int i = 0; i < model_fifo.size(); i++) begin
      int got;
      got = (i < pop_q.size()) ? int'(pop_q[i]) : -1;
      total++;
      if (got !== int'(model_fifo[i])) begin
        bad++; $display("FAIL fill_data[%0d] got=%0h exp=%0h", i, got, model_fifo[i]);
      end
    end
    for (int i = 1; i < pop_cyc.size(); i++) begin
      total++;
      if (pop_cyc[i] - pop_cyc[i-1] !== 1) begin
        bad++; $display("FAIL fill_consecutive[%0d] got=%0d exp=1", i, pop_cyc[i] - pop_cyc[i-1]);
      end
    end
    total++;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL fill_empty got=%b exp=0", m_valid); end
    model_fifo.delete();
  endtask

  task automatic test_frame_err();
    int f0;
    f0 = fe_cnt;
    pop_q.delete();
    send_frame(8'h55, 1'b0);
    repeat (20) @(posedge clk); #1;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL ferr_busy_break got=%b exp=1", busy); end
    total++;
    if (fe_cnt - f0 !== 1) begin bad++; $display("FAIL ferr_pulses got=%0d exp=1", fe_cnt - f0); end
    total++;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL ferr_no_push got=%b exp=0", m_valid); end
    rx_in = 1'b1;
    repeat (4) @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL ferr_release got=%b exp=0", busy); end
    m_ready = 1'b1;
    send_frame(8'h12, 1'b1);
    repeat (4) @(posedge clk);
    #1 m_ready = 1'b0;
    total++;
    if (pop_q.size() !== 1 || pop_q[0] !== 8'h12) begin
      bad++; $display("FAIL ferr_next_byte got=%0d entries head=%h exp=1 entries head=12",
                      pop_q.size(), (pop_q.size() > 0) ? pop_q[0] : 8'h00);
    end
  endtask

  task automatic test_overrun();
    int o0;
    model_fifo.delete(); exp_ov = 0;
    o0 = ov_cnt;
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      model_rx(byte'(i));
    end
    repeat (3) @(posedge clk); #1;
    total++;
    if (ov_cnt - o0 !== exp_ov) begin bad++; $display("FAIL ovr_pulses got=%0d exp=%0d", ov_cnt - o0, exp_ov); end
    pop_q.delete();
    drain();
    total++;
    if (pop_q.size() !== model_fifo.size()) begin
      bad++; $display("FAIL ovr_count got=%0d exp=%0d", pop_q.size(), model_fifo.size());
    end
    for (int i = 0; i < model_fifo.size(); i++) begin
      int got;
      got = (i < pop_q.size()) ? int'(pop_q[i]) : -1;
      total++;
      if (got !== int'(model_fifo[i])) begin
        bad++; $display("FAIL ovr_data[%0d] got=%0h exp=%0h", i, got, model_fifo[i]);
      end
    end
    model_fifo.delete();
  endtask

  task automatic test_pop_at_stop();
    int o0;
    byte unsigned exp_q[$];
    m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      byte unsigned b;
      b = byte'($urandom_range(0, 255));
      send_frame(b, 1'b1);
      exp_q.push_back(b);
    end
    exp_q.push_back(8'h77);
    o0 = ov_cnt;
    pop_q.delete();
    // Hold m_ready for exactly the cycle in which the stop bit is sampled.
    fork
      send_frame(8'h77, 1'b1);
      begin
        @(posedge clk);
        repeat (78) @(posedge clk);
        #1 m_ready = 1'b1;
        @(posedge clk);
        #1 m_ready = 1'b0;
      end
    join
    repeat (3) @(posedge clk); #1;
    total++;
    if (ov_cnt - o0 !== 0) begin bad++; $display("FAIL popstop_overrun got=%0d exp=0", ov_cnt - o0); end
    total++;
    if (pop_q.size() !== 1) begin bad++; $display("FAIL popstop_single_pop got=%0d exp=1", pop_q.size()); end
    drain();
    total++;
    if (pop_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL popstop_count got=%0d exp=%0d", pop_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      int got;
      got = (i < pop_q.size()) ? int'(pop_q[i]) : -1;
      total++;
      if (got !== int'(exp_q[i])) begin
        bad++; $display("FAIL popstop_data[%0d] got=%0h exp=%0h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_glitch();
    int f0, o0;
    f0 = fe_cnt; o0 = ov_cnt;
    @(posedge clk); #1 rx_in = 1'b0;
    repeat (2) @(posedge clk); #1 rx_in = 1'b1;
    repeat (3) @(posedge clk); #1;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL glitch_start got=%b exp=1", busy); end
    repeat (12) @(posedge clk); #1;
    total++;
    if ({busy, m_valid} !== 2'b00) begin bad++; $display("FAIL glitch_idle got=%b exp=00", {busy, m_valid}); end
    total++;
    if ((fe_cnt - f0) + (ov_cnt - o0) !== 0) begin
      bad++; $display("FAIL glitch_errors got=%0d exp=0", (fe_cnt - f0) + (ov_cnt - o0));
    end
  endtask

  task automatic test_ena_abort();
    int v0;
    v0 = vld_cnt;
    m_ready = 1'b0;
    fork
      send_frame(8'h3A, 1'b1);
      begin
        repeat (30) @(posedge clk);
        #1 ena = 1'b0;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL ena_idle got=%b exp=0", busy); end
      end
    join
    repeat (3) @(posedge clk);
    #1 ena = 1'b1;
    repeat (3) @(posedge clk); #1;
    total++;
    if (vld_cnt - v0 !== 0) begin bad++; $display("FAIL ena_no_push got=%0d exp=0", vld_cnt - v0); end
  endtask

  task automatic test_rst_mid();
    m_ready = 1'b0;
    send_frame(8'h99, 1'b1);
    @(posedge clk); #1 rx_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      repeat (CPB) @(posedge clk);
      #1 rx_in = 1'(i & 1);
    end
    repeat (4) @(posedge clk); #1;
    total++;
    if ({busy, m_valid} !== 2'b11) begin bad++; $display("FAIL rst_pre got=%b exp=11", {busy, m_valid}); end
    rst = 1'b1; rx_in = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({m_valid, frame_err, overrun, busy, m_data} !== 12'h000) begin
      bad++; $display("FAIL rst_mid_outputs got=%h exp=000", {m_valid, frame_err, overrun, busy, m_data});
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    pop_q.delete();
    m_ready = 1'b1;
    send_frame(8'hC3, 1'b1);
    repeat (4) @(posedge clk);
    #1 m_ready = 1'b0;
    total++;
    if (pop_q.size() !== 1 || pop_q[0] !== 8'hC3) begin
      bad++; $display("FAIL rst_next_byte got=%0d entries head=%h exp=1 entries head=c3",
                      pop_q.size(), (pop_q.size() > 0) ? pop_q[0] : 8'h00);
    end
  endtask

  task automatic test_random();
    byte unsigned sent[$];
    int  f0, o0;
    bit  done;
    done = 1'b0;
    f0 = fe_cnt; o0 = ov_cnt;
    pop_q.delete();
    fork
      begin
        for (int n = 0; n < 8; n++) begin
          byte unsigned b;
          b = byte'($urandom_range(0, 255));
          sent.push_back(b);
          send_frame(b, 1'b1);
          repeat ($urandom_range(0, 6)) @(posedge clk);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 m_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    total++;
    if (pop_q.size() !== sent.size()) begin
      bad++; $display("FAIL rand_count got=%0d exp=%0d", pop_q.size(), sent.size());
    end
    for (int i = 0; i < sent.size(); i++) begin
      int got;
      got = (i < pop_q.size()) ? int'(pop_q[i]) : -1;
      total++;
      if (got !== int'(sent[i])) begin
        bad++; $display("FAIL rand_data[%0d] got=%0h exp=%0h", i, got, sent[i]);
      end
    end
    total++;
    if ((fe_cnt - f0) + (ov_cnt - o0) !== 0) begin
      bad++; $display("FAIL rand_errors got=%0d exp=0", (fe_cnt - f0) + (ov_cnt - o0));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fifo_fill();
    test_frame_err();
    test_overrun();
    test_pop_at_stop();
    test_glitch();
    test_ena_abort();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
